// File: rtl/jtag_dtm_if.sv
// Debug-module register bus between the DTM (master) and the debug module (slave).
// The slave drives register_read combinationally from the presented address.
interface jtag_dtm_if #(
  parameter int unsigned address_size = 8
) ();
  logic [address_size-1:0] address;
  logic [31:0]             register_write;
  logic                    write_en;
  logic                    read_en;
  logic [31:0]             register_read;

  modport master (
    output address,
    output register_write,
    output write_en,
    output read_en,
    input  register_read
  );

  modport slave (
    input  address,
    input  register_write,
    input  write_en,
    input  read_en,
    output register_read
  );
endinterface

// File: rtl/jtag_dtm.sv
// JTAG Debug Transport Module: IEEE 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS registers,
// turning completed DMI scans into single-cycle read/write strobes on the DM bus.
module jtag_dtm #(
  parameter int unsigned address_size  = 8,
  parameter logic [31:0] IDCODE_VALUE  = 32'h0000_0001,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  jtag_dtm_if.master dm
);

  localparam int unsigned DmiLen = address_size + 34;

  localparam logic [4:0] IrIdcode = 5'h01;
  localparam logic [4:0] IrDtmcs  = 5'h10;
  localparam logic [4:0] IrDmi    = 5'h11;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  typedef enum logic [1:0] {
    SelBypass,
    SelIdcode,
    SelDtmcs,
    SelDmi
  } dr_sel_e;

  tap_state_e state_q, state_d;
  dr_sel_e    drSel;

  logic [4:0]              ir_q, ir_d;
  logic [4:0]              irShift_q, irShift_d;
  logic [DmiLen-1:0]       dr_q, dr_d;

  logic [address_size-1:0] addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [1:0]              op_q, op_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [1:0]              sticky_q, sticky_d;

  logic                    pending;
  logic                    strobe;
  logic [1:0]              captureOp;
  logic [31:0]             dtmcsValue;
  logic [1:0]              drOp;
  logic [31:0]             drData;
  logic [address_size-1:0] drAddr;
  logic                    updDmi;
  logic                    updDtmcs;
  logic                    capDmi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TestLogicReset;
      ir_q      <= IrIdcode;
      irShift_q <= '0;
      dr_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      irShift_q <= irShift_d;
      dr_q      <= dr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_comb begin
    unique case (ir_q)
      IrIdcode: drSel = SelIdcode;
      IrDtmcs:  drSel = SelDtmcs;
      IrDmi:    drSel = SelDmi;
      default:  drSel = SelBypass;
    endcase
  end

  assign pending    = (cnt_q != 3'd0);
  assign strobe     = (cnt_q == 3'd1);
  // A capture during an outstanding access reports busy instead of the sticky status.
  assign captureOp  = pending ? 2'd3 : sticky_q;
  assign dtmcsValue = {17'd0, 3'(ACCESS_CYCLES), sticky_q, 6'(address_size), 4'd1};

  assign drOp   = dr_q[1:0];
  assign drData = dr_q[33:2];
  assign drAddr = dr_q[DmiLen-1:34];

  assign updDmi   = (state_q == UpdateDr)  && (drSel == SelDmi);
  assign updDtmcs = (state_q == UpdateDr)  && (drSel == SelDtmcs);
  assign capDmi   = (state_q == CaptureDr) && (drSel == SelDmi);

  always_comb begin
    ir_d      = ir_q;
    irShift_d = irShift_q;
    dr_d      = dr_q;
    if (state_d == TestLogicReset) begin
      ir_d = IrIdcode;
    end
    unique case (state_q)
      CaptureIr: irShift_d = 5'b00001;
      ShiftIr:   irShift_d = {tdi, irShift_q[4:1]};
      UpdateIr:  ir_d      = irShift_q;
      CaptureDr: begin
        unique case (drSel)
          SelIdcode: dr_d = DmiLen'(IDCODE_VALUE);
          SelDtmcs:  dr_d = DmiLen'(dtmcsValue);
          SelDmi:    dr_d = {addr_q, data_q, captureOp};
          default:   dr_d = '0;
        endcase
      end
      // Shorter registers live in the low bits; tdi enters at the selected register's MSB.
      ShiftDr: begin
        dr_d = {1'b0, dr_q[DmiLen-1:1]};
        unique case (drSel)
          SelIdcode: dr_d[31]        = tdi;
          SelDtmcs:  dr_d[31]        = tdi;
          SelDmi:    dr_d[DmiLen-1]  = tdi;
          default:   dr_d[0]         = tdi;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (pending) begin
      cnt_d = cnt_q - 3'd1;
    end
    if (strobe && (op_q == 2'd1)) begin
      data_d = dm.register_read;
    end
    if (capDmi && pending) begin
      sticky_d = 2'd3;
    end
    if (updDmi && (sticky_q == 2'd0)) begin
      if (pending) begin
        sticky_d = 2'd3;
      end else if ((drOp == 2'd1) || (drOp == 2'd2)) begin
        addr_d = drAddr;
        data_d = drData;
        op_d   = drOp;
        cnt_d  = 3'(ACCESS_CYCLES);
      end
    end
    // A hard reset in the strobe cycle lets the strobe finish: the counter is at 1 anyway.
    if (updDtmcs && (dr_q[16] || dr_q[17])) begin
      sticky_d = 2'd0;
    end
    if (updDtmcs && dr_q[17]) begin
      cnt_d = 3'd0;
    end
  end

  assign dm.address        = addr_q;
  assign dm.register_write = data_q;
  assign dm.write_en       = strobe && (op_q == 2'd2);
  assign dm.read_en        = strobe && (op_q == 2'd1);

  assign tdo_en = (state_q == ShiftIr) || (state_q == ShiftDr);
  assign tdo    = (state_q == ShiftIr) ? irShift_q[0] :
                  (state_q == ShiftDr) ? dr_q[0]      : 1'b0;

endmodule

// File: tb/tb_jtag_dtm.sv
// Scoreboard bench for jtag_dtm: scan tasks drive the TAP, a transaction-level model
// predicts captured scans and DM strobes, and a negedge monitor pops and compares them.
module tb_jtag_dtm;
  localparam int AW = 8;
  localparam int AC = 7;
  localparam logic [31:0] IDC = 32'h4BA0_0477;
  localparam int DmiLen = AW + 34;

  logic clk = 1'b0;
  logic rst, tms, tdi, tdo, tdo_en;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  jtag_dtm_if #(.address_size(AW)) dm ();

  jtag_dtm #(
    .address_size(AW),
    .IDCODE_VALUE(IDC),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tms(tms),
    .tdi(tdi),
    .tdo(tdo),
    .tdo_en(tdo_en),
    .dm(dm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initVal(input logic [7:0] a);
    if (a == 8'h11) return 32'h1234_5678;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Debug module: storage holds the difference from the initial contents.
  logic [31:0] dmMem [256] = '{default: 32'h0};
  always @(posedge clk) if (dm.write_en) dmMem[dm.address] <= dm.register_write ^ initVal(dm.address);
  assign dm.register_read = dmMem[dm.address] ^ initVal(dm.address);

  typedef struct { int cyc; bit isWrite; logic [7:0] addr; logic [31:0] data; } strobeExp_t;
  typedef struct { logic [63:0] val; int len; } scanExp_t;
  strobeExp_t strbQ[$];
  scanExp_t   scanQ[$];

  // Reference model state at transaction level.
  logic [31:0] refMem [256];
  int          irM;
  int          sticky;
  bit          active;
  int          aU;
  bit          aRead;
  logic [7:0]  aAddr;
  logic [31:0] aData;
  logic [7:0]  mAddr;
  logic [31:0] mData;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int drLen(input int ir);
    case (ir)
      1, 16:   return 32;
      17:      return DmiLen;
      default: return 1;
    endcase
  endfunction

  function automatic logic [63:0] dmiVec(input logic [7:0] a, input logic [31:0] d, input logic [1:0] op);
    return (64'(a) << 34) | (64'(d) << 2) | 64'(op);
  endfunction

  task automatic modelComplete();
    if (aRead) mData = refMem[aAddr];
    else       refMem[aAddr] = aData;
    active = 0;
  endtask

  task automatic modelSettle(input int e);
    if (active && (aU + AC < e)) modelComplete();
  endtask

  function automatic bit pendingAt(input int e);
    return active && (e <= aU + AC);
  endfunction

  task automatic modelCapture(input int e);
    scanExp_t s;
    logic [1:0] op;
    modelSettle(e);
    s.len = drLen(irM);
    case (irM)
      1:  s.val = 64'(IDC);
      16: s.val = 64'd1 | (64'(AW) << 4) | (64'(sticky) << 10) | (64'(AC) << 12);
      17: begin
        op = pendingAt(e) ? 2'd3 : 2'(sticky);
        if (pendingAt(e)) sticky = 3;
        s.val = dmiVec(mAddr, mData, op);
      end
      default: s.val = 64'd0;
    endcase
    scanQ.push_back(s);
  endtask

  task automatic modelUpdate(input int e, input logic [63:0] v);
    strobeExp_t s;
    modelSettle(e);
    if (irM == 16) begin
      if (v[17]) begin
        if (active) begin
          if (e == aU + AC) modelComplete();
          else begin
            if (strbQ.size() > 0) strbQ.delete(strbQ.size() - 1);
            active = 0;
          end
        end
        sticky = 0;
      end else if (v[16]) begin
        sticky = 0;
      end
    end else if (irM == 17 && sticky == 0) begin
      if (pendingAt(e)) sticky = 3;
      else if (v[1:0] == 2'd1 || v[1:0] == 2'd2) begin
        active = 1; aU = e; aRead = (v[1:0] == 2'd1);
        aAddr = v[41:34]; aData = v[33:2];
        mAddr = aAddr; mData = aData;
        s.cyc = e + AC - 1; s.isWrite = !aRead; s.addr = aAddr; s.data = aData;
        strbQ.push_back(s);
      end
    end
  endtask

  task automatic modelReset(input int e);
    modelSettle(e);
    if (active) begin
      if (e < aU + AC) begin
        if (strbQ.size() > 0) strbQ.delete(strbQ.size() - 1);
      end else if (!aRead) refMem[aAddr] = aData;
    end
    active = 0; sticky = 0; mAddr = '0; mData = '0; irM = 1;
  endtask

  task automatic tick(input logic t, input logic d);
    tms = t; tdi = d;
    @(posedge clk); #1;
  endtask

  task automatic tapReset();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom));
    irM = 1;
    tick(1'b0, 1'b0);
  endtask

  task automatic scanIR(input logic [4:0] v);
    scanExp_t s;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    s.val = 64'd1; s.len = 5;
    scanQ.push_back(s);
    for (int i = 0; i < 5; i++) tick(i == 4, v[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    irM = int'(v);
  endtask

  task automatic scanDR(input logic [63:0] v, input bit fromSel, input bit toSel);
    int len = drLen(irM);
    if (!fromSel) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    modelCapture(cyc);
    for (int i = 0; i < len; i++) tick(i == len - 1, v[i]);
    tick(1'b1, 1'b0);
    tick(toSel, 1'b0);
    modelUpdate(cyc, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom));
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick(1'b1, 1'b0);
    modelReset(cyc);
    tick(1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("rst_address", 64'(dm.address), 64'd0);
    checkOutput("rst_register_write", 64'(dm.register_write), 64'd0);
    checkOutput("rst_write_en", 64'(dm.write_en), 64'd0);
    checkOutput("rst_read_en", 64'(dm.read_en), 64'd0);
    checkOutput("rst_tdo", 64'(tdo), 64'd0);
    checkOutput("rst_tdo_en", 64'(tdo_en), 64'd0);
    tick(1'b0, 1'b0);
  endtask

  // Monitor: strobes against the strobe queue, completed shift windows against the scan queue.
  strobeExp_t  monS;
  scanExp_t    monC;
  logic [63:0] capBits = '0;
  int          nbits = 0;
  always @(negedge clk) begin
    if (dm.write_en || dm.read_en) begin
      if (strbQ.size() == 0) checkOutput("unexpected_strobe", 64'({dm.write_en, dm.read_en}), 64'd0);
      else begin
        monS = strbQ.pop_front();
        checkOutput("strobe_cycle", 64'(cyc), 64'(monS.cyc));
        checkOutput("strobe_kind", 64'({dm.write_en, dm.read_en}), monS.isWrite ? 64'd2 : 64'd1);
        checkOutput("strobe_addr", 64'(dm.address), 64'(monS.addr));
        if (monS.isWrite) checkOutput("strobe_wdata", 64'(dm.register_write), 64'(monS.data));
      end
    end
    if (tdo_en) begin
      if (nbits < 64) capBits[nbits] = tdo;
      nbits++;
    end else if (nbits > 0) begin
      if (scanQ.size() == 0) checkOutput("unexpected_scan", 64'(nbits), 64'd0);
      else begin
        monC = scanQ.pop_front();
        checkOutput("scan_len", 64'(nbits), 64'(monC.len));
        checkOutput("scan_data", capBits, monC.val);
      end
      capBits = '0;
      nbits = 0;
    end
  end

  task automatic applyStimulus();
    logic [63:0] v;
    int r;
    applyReset();
    tapReset();
    scanDR(64'd0, 0, 0);
    scanIR(5'h10);
    scanDR(64'd0, 0, 0);
    scanIR(5'h11);
    scanDR(dmiVec(8'h04, 32'hDEAD_BEEF, 2'd2), 0, 0);
    checkOutput("wr_address", 64'(dm.address), 64'h04);
    checkOutput("wr_register_write", 64'(dm.register_write), 64'hDEAD_BEEF);
    idle(8);
    scanDR(dmiVec(8'h11, 32'h0, 2'd1), 0, 0);
    idle(8);
    scanDR(dmiVec(8'h00, 32'h0, 2'd0), 0, 0);
    // Busy: re-capture right after a read, then the ignored write and recovery.
    scanDR(dmiVec(8'h20, 32'h0, 2'd1), 0, 1);
    scanDR(dmiVec(8'h05, 32'hCAFE_F00D, 2'd2), 1, 0);
    idle(3);
    scanDR(dmiVec(8'h05, 32'hCAFE_F00D, 2'd2), 0, 0);
    scanIR(5'h10);
    scanDR(64'h1_0000, 0, 0);
    scanDR(64'd0, 0, 0);
    scanIR(5'h11);
    scanDR(dmiVec(8'h05, 32'hCAFE_F00D, 2'd2), 0, 0);
    idle(8);
    scanDR(dmiVec(8'h05, 32'h0, 2'd1), 0, 0);
    idle(8);
    scanDR(dmiVec(8'h06, 32'h600D_600D, 2'd2), 0, 0);
    applyReset();
    scanDR(64'd0, 0, 0);
    scanIR(5'h11);
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          case ($urandom_range(0, 5))
            0:       scanIR(5'h01);
            1:       scanIR(5'h10);
            2, 3:    scanIR(5'h11);
            4:       scanIR(5'($urandom_range(0, 31)));
            default: scanIR(5'h1F);
          endcase
        end
        2, 3, 4, 5: begin
          if (irM == 17) begin
            v = dmiVec(8'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
              scanDR(v, 0, 1);
              scanDR(dmiVec(8'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3))), 1, 0);
            end else scanDR(v, 0, 0);
          end else if (irM == 16) begin
            v = '0;
            v[16] = 1'($urandom_range(0, 1));
            v[17] = ($urandom_range(0, 3) == 0);
            scanDR(v, 0, 0);
          end else scanDR({$urandom, $urandom}, 0, 0);
        end
        6, 7: idle($urandom_range(1, 10));
        8: tapReset();
        default: scanIR(irM == 17 ? 5'h10 : 5'h11);
      endcase
    end
    idle(20);
  endtask

  initial begin
    rst = 1'b1; tms = 1'b1; tdi = 1'b0;
    for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
    irM = 1; sticky = 0; active = 0; aU = 0; aRead = 0;
    aAddr = '0; aData = '0; mAddr = '0; mData = '0;
    applyStimulus();
    checkOutput("strobe_queue_drained", 64'(strbQ.size()), 64'd0);
    checkOutput("scan_queue_drained", 64'(scanQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
